// File: rtl/frv_counters_pkg.sv
// Shared register map and encodings for the multi-channel counter/timer block.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package frv_counters_pkg;

  // Fixed register offsets, relative to the MMIO window base
  localparam logic [31:0] OFF_MTIME_LO = 32'h0000_0000;
  localparam logic [31:0] OFF_MTIME_HI = 32'h0000_0004;
  localparam logic [31:0] OFF_PRESC    = 32'h0000_0008;
  localparam logic [31:0] OFF_IE       = 32'h0000_000C;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_0010;
  localparam logic [31:0] OFF_MODE     = 32'h0000_0014;

  // Per-channel banks: compare registers, then reload periods
  localparam logic [31:0] CMP_BASE     = 32'h0000_0020;
  localparam logic [31:0] PERIOD_BASE  = 32'h0000_0060;
  localparam logic [31:0] CH_STRIDE    = 32'h0000_0008;

  // Mode bit per channel
  typedef enum logic {
    CMP_ONESHOT  = 1'b0,
    CMP_PERIODIC = 1'b1
  } cmp_mode_e;

  // Offset of the low word of mtimecmp[ch]
  function automatic logic [31:0] cmp_lo_off(input int ch);
    return CMP_BASE + CH_STRIDE * 32'(ch);
  endfunction

  // Offset of the low word of period[ch]
  function automatic logic [31:0] per_lo_off(input int ch);
    return PERIOD_BASE + CH_STRIDE * 32'(ch);
  endfunction

endpackage

// File: rtl/frv_cmp_channel.sv
// One compare channel: mtimecmp, period, mode, sticky status with optional auto-reload.
// Latency: status/reload take effect one cycle after mtime >= mtimecmp is seen.
// Backpressure: none; MMIO writes to cmp override a reload in the same cycle.
module frv_cmp_channel
  import frv_counters_pkg::*;
#(
  parameter int CTR_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CTR_W-1:0] mtime,
  input  logic             wr_cmp_lo,
  input  logic             wr_cmp_hi,
  input  logic             wr_per_lo,
  input  logic             wr_per_hi,
  input  logic             wr_mode,
  input  logic [31:0]      wdata,
  input  logic             mode_wdata,
  input  logic             clr_status,
  output logic [CTR_W-1:0] cmp,
  output logic [CTR_W-1:0] period,
  output logic             periodic,
  output logic             status
);

  cmp_mode_e mode;
  logic      match;

  assign match    = (mtime >= cmp);
  assign periodic = (mode == CMP_PERIODIC);

  // Compare register: software write beats the periodic reload
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp <= '0;
    end else if (wr_cmp_lo) begin
      cmp[31:0] <= wdata;
    end else if (wr_cmp_hi) begin
      cmp[CTR_W-1:32] <= wdata[CTR_W-33:0];
    end else if (match && periodic) begin
      cmp <= cmp + period;
    end
  end

  // Period and mode registers, software-owned
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
      mode   <= CMP_ONESHOT;
    end else begin
      if (wr_per_lo) period[31:0] <= wdata;
      if (wr_per_hi) period[CTR_W-1:32] <= wdata[CTR_W-33:0];
      if (wr_mode)   mode <= cmp_mode_e'(mode_wdata);
    end
  end

  // Sticky status: a match in the same cycle as a W1C keeps the bit set
  always_ff @(posedge clk) begin
    if (reset) status <= 1'b0;
    else       status <= match | (status & ~clr_status);
  end

endmodule

// File: rtl/frv_counters_mc.sv
// Prescaled mtime, cycle/instret counters and NCMP compare channels behind an MMIO window.
// Latency: MMIO read data/error registered, valid one cycle after mmio_en, held until next request.
// Backpressure: none; every request is accepted in the cycle it is presented.
module frv_counters_mc
  import frv_counters_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000,
  parameter int          CTR_W          = 64,
  parameter int          NCMP           = 4,
  parameter int          PRESC_W        = 16
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            instr_ret,
  input  logic            inhibit_cy,
  input  logic            inhibit_tm,
  input  logic            inhibit_ir,
  output logic [63:0]     ctr_time,
  output logic [63:0]     ctr_cycle,
  output logic [63:0]     ctr_instret,
  output logic [NCMP-1:0] timer_interrupt,
  input  logic            mmio_en,
  input  logic            mmio_wen,
  input  logic [31:0]     mmio_addr,
  input  logic [31:0]     mmio_wdata,
  output logic [31:0]     mmio_rdata,
  output logic            mmio_error
);

  logic [CTR_W-1:0]   mtime;
  logic [PRESC_W-1:0] prescale;
  logic [PRESC_W-1:0] pcount;
  logic [NCMP-1:0]    ie;
  logic [NCMP-1:0]    status;
  logic [NCMP-1:0]    periodic;
  logic [CTR_W-1:0]   cmp    [NCMP];
  logic [CTR_W-1:0]   period [NCMP];

  // Zero-extended views used for readback
  logic [63:0] mtime_x;
  logic [63:0] cmp_x [NCMP];
  logic [63:0] per_x [NCMP];
  logic [31:0] presc_x;
  logic [31:0] ie_x;
  logic [31:0] status_x;
  logic [31:0] mode_x;

  // Decode
  logic        in_win;
  logic [31:0] off;
  logic        mapped;
  logic [31:0] rd_val;
  logic        wr_en;
  logic        sel_mtime_lo, sel_mtime_hi, sel_presc, sel_ie, sel_status, sel_mode;
  logic [NCMP-1:0] sel_cmp_lo, sel_cmp_hi, sel_per_lo, sel_per_hi;
  logic        wr_mtime_lo, wr_mtime_hi, wr_presc, wr_ie, wr_status, wr_mode;
  logic [NCMP-1:0] wr_cmp_lo, wr_cmp_hi, wr_per_lo, wr_per_hi;
  logic [NCMP-1:0] status_clr;
  logic        tick;

  assign in_win = ((mmio_addr & MMIO_BASE_MASK) == (MMIO_BASE_ADDR & MMIO_BASE_MASK));
  assign off    = mmio_addr & ~MMIO_BASE_MASK;
  assign wr_en  = mmio_en & mmio_wen & in_win & mapped;

  assign wr_mtime_lo = wr_en & sel_mtime_lo;
  assign wr_mtime_hi = wr_en & sel_mtime_hi;
  assign wr_presc    = wr_en & sel_presc;
  assign wr_ie       = wr_en & sel_ie;
  assign wr_status   = wr_en & sel_status;
  assign wr_mode     = wr_en & sel_mode;
  assign wr_cmp_lo   = {NCMP{wr_en}} & sel_cmp_lo;
  assign wr_cmp_hi   = {NCMP{wr_en}} & sel_cmp_hi;
  assign wr_per_lo   = {NCMP{wr_en}} & sel_per_lo;
  assign wr_per_hi   = {NCMP{wr_en}} & sel_per_hi;
  assign status_clr  = wr_status ? mmio_wdata[NCMP-1:0] : '0;

  // A prescale write restarts the prescaler, so no mtime tick that cycle
  assign tick = !inhibit_tm && !wr_presc && (pcount == prescale);

  assign ctr_time        = mtime_x;
  assign timer_interrupt = status & ie;

  // Zero-extend narrow registers into 32/64-bit readback views
  always_comb begin
    mtime_x  = '0;
    presc_x  = '0;
    ie_x     = '0;
    status_x = '0;
    mode_x   = '0;
    mtime_x[CTR_W-1:0]   = mtime;
    presc_x[PRESC_W-1:0] = prescale;
    ie_x[NCMP-1:0]       = ie;
    status_x[NCMP-1:0]   = status;
    mode_x[NCMP-1:0]     = periodic;
    for (int i = 0; i < NCMP; i++) begin
      cmp_x[i] = '0;
      per_x[i] = '0;
      cmp_x[i][CTR_W-1:0] = cmp[i];
      per_x[i][CTR_W-1:0] = period[i];
    end
  end

  // Offset decode and readback mux; unmapped offsets read 0 and flag an error
  always_comb begin
    mapped       = 1'b0;
    rd_val       = '0;
    sel_mtime_lo = 1'b0;
    sel_mtime_hi = 1'b0;
    sel_presc    = 1'b0;
    sel_ie       = 1'b0;
    sel_status   = 1'b0;
    sel_mode     = 1'b0;
    sel_cmp_lo   = '0;
    sel_cmp_hi   = '0;
    sel_per_lo   = '0;
    sel_per_hi   = '0;
    case (off)
      OFF_MTIME_LO: begin mapped = 1'b1; sel_mtime_lo = 1'b1; rd_val = mtime_x[31:0];  end
      OFF_MTIME_HI: begin mapped = 1'b1; sel_mtime_hi = 1'b1; rd_val = mtime_x[63:32]; end
      OFF_PRESC:    begin mapped = 1'b1; sel_presc    = 1'b1; rd_val = presc_x;        end
      OFF_IE:       begin mapped = 1'b1; sel_ie       = 1'b1; rd_val = ie_x;           end
      OFF_STATUS:   begin mapped = 1'b1; sel_status   = 1'b1; rd_val = status_x;       end
      OFF_MODE:     begin mapped = 1'b1; sel_mode     = 1'b1; rd_val = mode_x;         end
      default: ;
    endcase
    for (int i = 0; i < NCMP; i++) begin
      if (off == cmp_lo_off(i)) begin
        mapped = 1'b1; sel_cmp_lo[i] = 1'b1; rd_val = cmp_x[i][31:0];
      end
      if (off == cmp_lo_off(i) + 32'd4) begin
        mapped = 1'b1; sel_cmp_hi[i] = 1'b1; rd_val = cmp_x[i][63:32];
      end
      if (off == per_lo_off(i)) begin
        mapped = 1'b1; sel_per_lo[i] = 1'b1; rd_val = per_x[i][31:0];
      end
      if (off == per_lo_off(i) + 32'd4) begin
        mapped = 1'b1; sel_per_hi[i] = 1'b1; rd_val = per_x[i][63:32];
      end
    end
  end

  // Prescaler and mtime; a software write to mtime drops that cycle's increment
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      prescale <= '0;
      pcount   <= '0;
      mtime    <= '0;
    end else begin
      if (wr_presc) begin
        prescale <= mmio_wdata[PRESC_W-1:0];
        pcount   <= '0;
      end else if (!inhibit_tm) begin
        pcount <= (pcount == prescale) ? '0 : pcount + 1'b1;
      end
      if (wr_mtime_lo)      mtime[31:0]       <= mmio_wdata;
      else if (wr_mtime_hi) mtime[CTR_W-1:32] <= mmio_wdata[CTR_W-33:0];
      else if (tick)        mtime             <= mtime + 1'b1;
    end
  end

  // Free-running cycle and retired-instruction counters
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      ctr_cycle   <= '0;
      ctr_instret <= '0;
    end else begin
      if (!inhibit_cy)             ctr_cycle   <= ctr_cycle + 1'b1;
      if (instr_ret && !inhibit_ir) ctr_instret <= ctr_instret + 1'b1;
    end
  end

  // Interrupt enable register
  always_ff @(posedge g_clk) begin
    if (g_reset)    ie <= '0;
    else if (wr_ie) ie <= mmio_wdata[NCMP-1:0];
  end

  // Registered MMIO response, held until the next request
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      mmio_rdata <= '0;
      mmio_error <= 1'b0;
    end else if (mmio_en) begin
      mmio_rdata <= in_win ? rd_val : '0;
      mmio_error <= in_win && !mapped;
    end
  end

  for (genvar i = 0; i < NCMP; i++) begin : g_ch
    frv_cmp_channel #(
      .CTR_W(CTR_W)
    ) u_ch (
      .clk        (g_clk),
      .reset      (g_reset),
      .mtime      (mtime),
      .wr_cmp_lo  (wr_cmp_lo[i]),
      .wr_cmp_hi  (wr_cmp_hi[i]),
      .wr_per_lo  (wr_per_lo[i]),
      .wr_per_hi  (wr_per_hi[i]),
      .wr_mode    (wr_mode),
      .wdata      (mmio_wdata),
      .mode_wdata (mmio_wdata[i]),
      .clr_status (status_clr[i]),
      .cmp        (cmp[i]),
      .period     (period[i]),
      .periodic   (periodic[i]),
      .status     (status[i])
    );
  end

endmodule

// File: doc/frv_counters_mc.md
Name: frv_counters_mc

Overview:
- Parametrised successor to the single-channel counter/timer block.
- Provides a prescaled mtime counter of configurable width, cycle/instret counters with inhibits, and NCMP independent compare channels, each one-shot or periodic (auto-reload), with sticky W1C status and per-channel interrupt lines.
- Sits beside the pipeline on the MMIO port; timer_interrupt[0] feeds the interrupt controller's ti_pending, other channels go to the external-interrupt fabric.

Parameters:
- MMIO_BASE_ADDR, 32'h0000_1000, base of the register window.
- MMIO_BASE_MASK, 32'hFFFF_F000, mask selecting the window.
- CTR_W, 64, width of mtime and compare registers (33..64); bits above CTR_W read 0, writes ignored.
- NCMP, 4, number of compare channels (1..8).
- PRESC_W, 16, prescaler register width (1..32).

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  synchronous reset, active-high.
- instr_ret  in  1  instruction retired pulse.
- inhibit_cy  in  1  freeze cycle counter.
- inhibit_tm  in  1  freeze mtime and prescaler.
- inhibit_ir  in  1  freeze instret counter.
- ctr_time  out  64  mtime, zero-extended.
- ctr_cycle  out  64  cycle counter.
- ctr_instret  out  64  instret counter.
- timer_interrupt  out  NCMP  per-channel interrupt = status[i] & ie[i].
- mmio_en  in  1  MMIO request.
- mmio_wen  in  1  MMIO write enable.
- mmio_addr  in  32  MMIO byte address (word aligned).
- mmio_wdata  in  32  MMIO write data.
- mmio_rdata  out  32  read data, registered.
- mmio_error  out  1  error, registered.

Behaviour:
- Reset values: all counters, mtimecmp, period, prescaler reg/count, ctrl, status = 0; mmio_rdata = 0; mmio_error = 0; timer_interrupt = 0.
- Register map, offsets from MMIO_BASE_ADDR:
  - 0x00/0x04: mtime lo/hi.
  - 0x08: prescale.
  - 0x0C: ie[NCMP-1:0].
  - 0x10: status (W1C).
  - 0x14: mode (bit i = periodic).
  - 0x20+8i / 0x24+8i: mtimecmp[i] lo/hi.
  - 0x60+8i / 0x64+8i: period[i] lo/hi.
- Prescaler: when !inhibit_tm, pcount increments each cycle. When pcount == prescale, pcount <= 0 and mtime increments (wraps modulo 2^CTR_W). prescale = 0 gives +1 per cycle.
- Prescale write: pcount reset to 0 in the same cycle.
- ctr_cycle increments every cycle unless inhibit_cy. ctr_instret increments on instr_ret unless inhibit_ir. Both are read-only via CSRs, not MMIO.
- Match: match[i] = (mtime >= mtimecmp[i]), unsigned, evaluated on registered values each cycle.
- One-shot channel: status[i] <= 1 every cycle match[i] holds.
- Periodic channel: on match[i], status[i] <= 1 and mtimecmp[i] <= mtimecmp[i] + period[i] (mod 2^CTR_W). period = 0 degenerates to level behaviour.
- W1C to status clears written bits. Set and clear in the same cycle: set wins.
- Simultaneous MMIO write and hardware update of the same register (mtime increment, cmp reload): MMIO write wins; the increment/reload is dropped that cycle.
- 64-bit registers are written one 32-bit half per access with no hi/lo latching. Software writes hi then lo.
- MMIO latency: request sampled when mmio_en; rdata/error valid exactly one cycle later and held until the next request. No back-pressure.
- Address outside window: no effect, rdata 0, error 0.
- Inside window but unmapped offset, or channel index >= NCMP: error 1, rdata 0, no write.
- Reset mid-operation: all state returns to reset values next edge; a pending MMIO response is dropped (rdata 0, error 0).

Decomposition:
- Shared package frv_counters_pkg:
  - Register offset constants.
  - Channel stride (8) and period base (0x60).
  - Mode bit encoding.
- Sub-module frv_cmp_channel, instantiated NCMP times via generate. Owns mtimecmp, period, mode, status and the match/reload logic.
- Top level owns the prescaler, counters and MMIO decode/readback mux.

Test Plan:
- Reset then idle 10 cycles, prescale 0 -> ctr_time = 10, ctr_cycle = 10, all interrupts 0, rdata 0.
- Write prescale = 3, run 16 cycles with inhibit_tm = 0 -> mtime advanced by 4. Assert inhibit_tm 8 cycles -> mtime unchanged.
- Channel 1 one-shot, cmp = 20, ie = 0x2 -> timer_interrupt[1] rises the cycle after mtime = 20. W1C status 0x2 -> bit re-sets next cycle; after cmp = 0xFFFF_FFFF_FFFF_FFFF, W1C leaves it at 0.
- Channel 0 periodic, cmp = 10, period = 5, prescale 0 -> status sets at mtime 10, 15, 20; cmp reads 25 after the third match.
- Read offset 0x18 -> mmio_error = 1, rdata 0. Read 0x20+8·NCMP -> error 1. Address 0x2000 -> error 0.
- MMIO write mtime lo = 0x100 on an increment cycle -> next read returns 0x100 (write wins), then 0x101 after one tick.
